imem_responder: RTL

- Instruction-memory responder: the memory side of the fetch stage's address/instruction/ready interface.
- Accepts one fetch address at a time and returns the 32-bit word after a fixed, configurable latency; signals ready via a valid/ready handshake.
- Honours a fetch flush on branch/jump redirect.
- Provides a word-write load port for boot/bench program loading.
- Replaces the combinational ROM so fetch can be exercised against multi-cycle memory.

---
 rtl/imem_pkg.sv | 25 ++
 rtl/imem_if.sv | 24 ++
 rtl/imem_array.sv | 53 +++++
 rtl/imem_responder.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared constants and types for the instruction-memory responder.
package imem_pkg;

    // Bubble instruction: add x0, x0, x0
    localparam logic [31:0] IMEM_NOP_INSTR = 32'h0000_0033;

    // Legal response latency range, in cycles
    localparam int unsigned IMEM_MIN_LATENCY = 1;
    localparam int unsigned IMEM_MAX_LATENCY = 15;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Why a response carries resp_err; kept internally for debug visibility
    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_MISALIGN,
        ERR_RANGE,
        ERR_PARITY
    } err_cause_t;

endpackage

// File: rtl/imem_if.sv
// imem_if: fetch-side request/response handshake between the fetch stage
// (master) and the instruction-memory responder (slave).
interface imem_if;

    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instr;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, flush, resp_ready,
        input  req_ready, resp_valid, resp_instr, resp_err
    );

    modport slave (
        input  req_valid, req_addr, flush, resp_ready,
        output req_ready, resp_valid, resp_instr, resp_err
    );

endinterface

// File: rtl/imem_array.sv
// imem_array: word storage with synchronous write (load port) and
// combinational read. With IMEM_PARITY_EN defined each word carries an
// even-parity bit generated on write and checked on read.
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    output logic              rd_parity_err
);

`ifdef IMEM_PARITY_EN
    logic [32:0] mem [DEPTH_WORDS];
    logic [32:0] rd_word;

    // Load port: store the word with its even-parity bit in the MSB
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= {^ld_data, ld_data};
        end
    end

    // Read path: an odd total bit count means the stored word is corrupt
    always_comb begin
        rd_word       = mem[rd_addr];
        rd_data       = rd_word[31:0];
        rd_parity_err = ^rd_word;
    end
`else
    logic [31:0] mem [DEPTH_WORDS];

    // Load port: plain word write
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Read path: no integrity check without parity storage
    always_comb begin
        rd_data       = mem[rd_addr];
        rd_parity_err = 1'b0;
    end
`endif

endmodule

// File: rtl/imem_responder.sv
// imem_responder: memory side of the fetch interface. Accepts one fetch
// address at a time and returns the word LATENCY cycles later through a
// valid/ready response, with flush and a word-write load port.
// Optional macro IMEM_PARITY_EN enables per-word parity in imem_array.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned  DEPTH_WORDS = 1024,
    parameter int unsigned  LATENCY     = 2,
    parameter logic [31:0]  NOP_INSTR   = IMEM_NOP_INSTR,
    localparam int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    imem_if.slave             bus,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data
);

    generate
        if (LATENCY < IMEM_MIN_LATENCY || LATENCY > IMEM_MAX_LATENCY) begin : g_bad_latency
            $error("imem_responder: LATENCY=%0d outside 1..15", LATENCY);
        end
    endgenerate

    // State entered on acceptance and the wait-counter preload for it
    localparam state_t     ACCEPT_STATE = (LATENCY > 1) ? WAIT : RESP;
    localparam logic [3:0] WAIT_LOAD    = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic [31:0] resp_instr_q;
    err_cause_t  err_cause_q;

    logic              accept;
    logic              misalign;
    logic              out_of_range;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic              rd_parity_err;
    logic [31:0]       req_instr;
    err_cause_t        req_cause;

    assign rd_addr      = bus.req_addr[ADDR_W+1:2];
    assign misalign     = |bus.req_addr[1:0];
    assign out_of_range = {2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS);

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_array (
        .clk           (clk),
        .ld_en         (ld_en),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_parity_err (rd_parity_err)
    );

    // Ready when idle or when the held response is being consumed; flush blocks it
    always_comb begin
        bus.req_ready = 1'b0;
        if (!bus.flush) begin
            bus.req_ready = (state == IDLE) || ((state == RESP) && bus.resp_ready);
        end
    end

    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_instr = resp_instr_q;
    assign bus.resp_err   = (err_cause_q != ERR_NONE);

    // Classify the request at acceptance; errors replace the data with a bubble
    always_comb begin
        req_cause = ERR_NONE;
        req_instr = rd_data;
        if (misalign) begin
            req_cause = ERR_MISALIGN;
        end else if (out_of_range) begin
            req_cause = ERR_RANGE;
        end else if (rd_parity_err) begin
            req_cause = ERR_PARITY;
        end
        if (req_cause != ERR_NONE) begin
            req_instr = NOP_INSTR;
        end
    end

    // Next-state logic; flush overrides every other transition
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ACCEPT_STATE;
                end
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_next = accept ? ACCEPT_STATE : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (bus.flush) begin
            state_next = IDLE;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Wait counter and response register, captured at acceptance
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            wait_cnt     <= '0;
            resp_instr_q <= NOP_INSTR;
            err_cause_q  <= ERR_NONE;
        end else if (accept) begin
            wait_cnt     <= WAIT_LOAD;
            resp_instr_q <= req_instr;
            err_cause_q  <= req_cause;
        end else if ((state == WAIT) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

endmodule
